// File: rtl/alu_operand_stage.sv
// Operand pipeline register feeding the 32-bit ALU: bypass resolution, immediate
// select and a valid/ready output register with flush.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [IMM_W-1:0]  imm,
  input  logic              use_imm,
  input  logic [2:0]        alu_sel_in,
  input  logic              reg_write_in,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [2:0]        sel,
  output logic [REG_AW-1:0] rd_out,
  output logic              reg_write_out,
  output logic              div_zero
);

  localparam logic [2:0] SEL_DIV = 3'b100;

  logic              capture;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] op2_next;
  logic [DATA_W-1:0] imm_ext;

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // MEM is the younger producer, so it wins over WB; r0 never forwards.
  always_comb begin
    rs_fwd = rs_data;
    if (rs_addr != '0) begin
      if (mem_wr_en && (mem_rd == rs_addr))
        rs_fwd = mem_data;
      else if (wb_wr_en && (wb_rd == rs_addr))
        rs_fwd = wb_data;
    end
  end

  always_comb begin
    rt_fwd = rt_data;
    if (rt_addr != '0) begin
      if (mem_wr_en && (mem_rd == rt_addr))
        rt_fwd = mem_data;
      else if (wb_wr_en && (wb_rd == rt_addr))
        rt_fwd = wb_data;
    end
  end

  assign imm_ext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign op2_next = use_imm ? imm_ext : rt_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      op1           <= '0;
      op2           <= '0;
      sel           <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      div_zero      <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
      div_zero      <= 1'b0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      op1           <= rs_fwd;
      op2           <= op2_next;
      sel           <= alu_sel_in;
      rd_out        <= rd_addr;
      reg_write_out <= reg_write_in;
      div_zero      <= (alu_sel_in == SEL_DIV) && (op2_next == '0);
    end else if (out_valid && out_ready) begin
      // Drained: payload stays, but side-effect flags are qualified off.
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
      div_zero      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: vector table for the datapath plus
// hand-written stall, flush and reset sequences.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imm;
  logic        use_imm;
  logic [2:0]  alu_sel_in;
  logic        reg_write_in;
  logic        mem_wr_en;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wb_wr_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] op1, op2;
  logic [2:0]  sel;
  logic [4:0]  rd_out;
  logic        reg_write_out, div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .use_imm(use_imm),
    .alu_sel_in(alu_sel_in), .reg_write_in(reg_write_in),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .sel(sel), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .div_zero(div_zero)
  );

  typedef struct {
    logic [4:0]  rs_a, rt_a, rd_a;
    logic [31:0] rs_d, rt_d;
    logic [15:0] imm_v;
    logic        use_i;
    logic [2:0]  sel_v;
    logic        rw;
    logic        mem_en;
    logic [4:0]  mem_r;
    logic [31:0] mem_d;
    logic        wb_en;
    logic [4:0]  wb_r;
    logic [31:0] wb_d;
    logic [31:0] exp_op1, exp_op2;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(
    input logic [4:0] rs_a, input logic [31:0] rs_d,
    input logic [4:0] rt_a, input logic [31:0] rt_d,
    input logic [4:0] rd_a, input logic [15:0] imm_v, input logic use_i,
    input logic [2:0] sel_v, input logic rw,
    input logic mem_en, input logic [4:0] mem_r, input logic [31:0] mem_d,
    input logic wb_en, input logic [4:0] wb_r, input logic [31:0] wb_d,
    input logic [31:0] exp_op1, input logic [31:0] exp_op2, input logic exp_dz);
    vec_t v;
    v.rs_a = rs_a; v.rs_d = rs_d; v.rt_a = rt_a; v.rt_d = rt_d; v.rd_a = rd_a;
    v.imm_v = imm_v; v.use_i = use_i; v.sel_v = sel_v; v.rw = rw;
    v.mem_en = mem_en; v.mem_r = mem_r; v.mem_d = mem_d;
    v.wb_en = wb_en; v.wb_r = wb_r; v.wb_d = wb_d;
    v.exp_op1 = exp_op1; v.exp_op2 = exp_op2; v.exp_dz = exp_dz;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0; rs_data = 0; rt_data = 0;
    imm = 0; use_imm = 0; alu_sel_in = 0; reg_write_in = 0;
    mem_wr_en = 0; mem_rd = 0; mem_data = 0; wb_wr_en = 0; wb_rd = 0; wb_data = 0;
    flush = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid = 1;
    rs_addr = v.rs_a; rs_data = v.rs_d; rt_addr = v.rt_a; rt_data = v.rt_d;
    rd_addr = v.rd_a; imm = v.imm_v; use_imm = v.use_i; alu_sel_in = v.sel_v;
    reg_write_in = v.rw; mem_wr_en = v.mem_en; mem_rd = v.mem_r; mem_data = v.mem_d;
    wb_wr_en = v.wb_en; wb_rd = v.wb_r; wb_data = v.wb_d;
  endtask

  task automatic simple_instr(input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] s, input logic rw);
    idle_inputs();
    in_valid = 1; rs_addr = 5'd1; rs_data = a; rt_addr = 5'd2; rt_data = b;
    rd_addr = 5'd9; alu_sel_in = s; reg_write_in = rw;
  endtask

  initial begin
    //            rs  rs_d          rt  rt_d          rd  imm       ui sel     rw mem              wb               op1           op2           dz
    vecs[0]  = mk(1,  32'd5,        2,  32'd7,        4,  16'h0000, 0, 3'b000, 1, 0, 0, 0,         0, 0, 0,         32'd5,        32'd7,        0);
    vecs[1]  = mk(1,  32'd1,        2,  32'd7,        5,  16'hFFFE, 1, 3'b001, 1, 0, 0, 0,         0, 0, 0,         32'd1,        32'hFFFFFFFE, 0);
    vecs[2]  = mk(1,  32'd2,        2,  32'd7,        6,  16'h7FFF, 1, 3'b010, 0, 0, 0, 0,         0, 0, 0,         32'd2,        32'h00007FFF, 0);
    vecs[3]  = mk(3,  32'h11,       2,  32'd7,        7,  16'h0000, 0, 3'b000, 1, 1, 3, 32'hAA,    1, 3, 32'hBB,    32'hAA,       32'd7,        0);
    vecs[4]  = mk(3,  32'h11,       2,  32'd7,        7,  16'h0000, 0, 3'b000, 1, 0, 3, 32'hAA,    1, 3, 32'hBB,    32'hBB,       32'd7,        0);
    vecs[5]  = mk(0,  32'h0,        2,  32'd7,        7,  16'h0000, 0, 3'b000, 1, 1, 0, 32'hAA,    1, 0, 32'hBB,    32'h0,        32'd7,        0);
    vecs[6]  = mk(1,  32'd3,        4,  32'd9,        8,  16'h0000, 0, 3'b011, 1, 1, 7, 32'h77,    1, 4, 32'h44,    32'd3,        32'h44,       0);
    vecs[7]  = mk(1,  32'd3,        4,  32'd9,        8,  16'h0010, 1, 3'b011, 1, 1, 4, 32'h77,    1, 4, 32'h44,    32'd3,        32'h10,       0);
    vecs[8]  = mk(1,  32'd100,      2,  32'd0,        9,  16'h0000, 0, 3'b100, 1, 0, 0, 0,         0, 0, 0,         32'd100,      32'd0,        1);
    vecs[9]  = mk(1,  32'd100,      2,  32'd4,        9,  16'h0000, 0, 3'b100, 1, 0, 0, 0,         0, 0, 0,         32'd100,      32'd4,        0);
    vecs[10] = mk(1,  32'd8,        2,  32'd4,        9,  16'h0000, 1, 3'b100, 0, 1, 2, 32'h5,     0, 0, 0,         32'd8,        32'd0,        1);
    vecs[11] = mk(1,  32'd8,        0,  32'h123,      9,  16'h0000, 0, 3'b101, 1, 1, 0, 32'h5,     1, 0, 32'h6,     32'd8,        32'h123,      0);

    idle_inputs();
    out_ready = 1;
    rst_n = 0;
    #1;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset op1", op1, 32'd0);
    check("reset op2", op2, 32'd0);
    check("reset div_zero", {31'b0, div_zero}, 32'd0);
    step();
    step();
    rst_n = 1;
    #1;
    check("in_ready after reset", {31'b0, in_ready}, 32'd1);

    // Back-to-back stream at full throughput.
    for (int i = 0; i < 12; i++) begin
      drive_vec(vecs[i]);
      step();
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("v%0d op1", i), op1, vecs[i].exp_op1);
      check($sformatf("v%0d op2", i), op2, vecs[i].exp_op2);
      check($sformatf("v%0d sel", i), {29'b0, sel}, {29'b0, vecs[i].sel_v});
      check($sformatf("v%0d rd_out", i), {27'b0, rd_out}, {27'b0, vecs[i].rd_a});
      check($sformatf("v%0d reg_write_out", i), {31'b0, reg_write_out}, {31'b0, vecs[i].rw});
      check($sformatf("v%0d div_zero", i), {31'b0, div_zero}, {31'b0, vecs[i].exp_dz});
      check($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
    end
    idle_inputs();
    step();
    check("drain out_valid", {31'b0, out_valid}, 32'd0);
    check("drain reg_write_out", {31'b0, reg_write_out}, 32'd0);
    check("drain op1 held", op1, 32'd8);

    // Backpressure: A held for three cycles while B waits upstream.
    simple_instr(32'h11, 32'h1, 3'b010, 1);
    out_ready = 0;
    step();
    check("bp A out_valid", {31'b0, out_valid}, 32'd1);
    simple_instr(32'h22, 32'h2, 3'b011, 1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp in_ready c%0d", c), {31'b0, in_ready}, 32'd0);
      step();
      check($sformatf("bp op1 c%0d", c), op1, 32'h11);
      check($sformatf("bp op2 c%0d", c), op2, 32'h1);
      check($sformatf("bp sel c%0d", c), {29'b0, sel}, 32'd2);
      check($sformatf("bp out_valid c%0d", c), {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1;
    #1;
    check("bp in_ready release", {31'b0, in_ready}, 32'd1);
    step();
    check("bp B out_valid", {31'b0, out_valid}, 32'd1);
    check("bp B op1", op1, 32'h22);
    check("bp B sel", {29'b0, sel}, 32'd3);
    idle_inputs();
    step();
    check("bp no duplicate", {31'b0, out_valid}, 32'd0);

    // Flush kills both the held and the incoming instruction.
    simple_instr(32'h33, 32'h0, 3'b100, 1);
    out_ready = 0;
    step();
    check("fl C out_valid", {31'b0, out_valid}, 32'd1);
    check("fl C div_zero", {31'b0, div_zero}, 32'd1);
    simple_instr(32'h44, 32'h4, 3'b000, 1);
    flush = 1;
    step();
    check("fl out_valid", {31'b0, out_valid}, 32'd0);
    check("fl reg_write_out", {31'b0, reg_write_out}, 32'd0);
    check("fl div_zero", {31'b0, div_zero}, 32'd0);
    idle_inputs();
    out_ready = 1;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("fl D absent c%0d", c), {31'b0, out_valid}, 32'd0);
    end

    // Asynchronous reset in the middle of a stall.
    simple_instr(32'h55, 32'h0, 3'b100, 1);
    out_ready = 0;
    step();
    check("rs pre out_valid", {31'b0, out_valid}, 32'd1);
    check("rs pre div_zero", {31'b0, div_zero}, 32'd1);
    step();
    #2;
    rst_n = 0;
    #1;
    check("rs out_valid", {31'b0, out_valid}, 32'd0);
    check("rs op1", op1, 32'd0);
    check("rs sel", {29'b0, sel}, 32'd0);
    check("rs rd_out", {27'b0, rd_out}, 32'd0);
    check("rs reg_write_out", {31'b0, reg_write_out}, 32'd0);
    check("rs div_zero", {31'b0, div_zero}, 32'd0);
    idle_inputs();
    step();
    rst_n = 1;
    #1;
    check("rs in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("rs stays empty", {31'b0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline register stage directly upstream of the 32-bit ALU: captures decoded operands, resolves bypassing, selects immediates, and presents registered op1/op2/sel to the ALU.
- Uses a valid/ready handshake so the execute stage can stall it.
- Supports flush, so branch/exception logic can inject a bubble.

Parameters:
- DATA_W, 32, operand and result width.
- REG_AW, 5, register-address width.
- IMM_W, 16, raw immediate width; sign-extended to DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decode presents a valid instruction.
- in_ready  output  1  stage can accept the instruction this cycle.
- rs_addr  input  REG_AW  source-1 register index.
- rt_addr  input  REG_AW  source-2 register index.
- rd_addr  input  REG_AW  destination register index.
- rs_data  input  DATA_W  register-file read for rs.
- rt_data  input  DATA_W  register-file read for rt.
- imm  input  IMM_W  raw immediate.
- use_imm  input  1  op2 comes from the sign-extended immediate instead of rt.
- alu_sel_in  input  3  ALU operation code (same encoding as the ALU sel).
- reg_write_in  input  1  instruction writes rd.
- mem_wr_en  input  1  MEM stage will write a register.
- mem_rd  input  REG_AW  MEM stage destination.
- mem_data  input  DATA_W  MEM stage result.
- wb_wr_en  input  1  WB stage writing a register.
- wb_rd  input  REG_AW  WB stage destination.
- wb_data  input  DATA_W  WB stage data.
- flush  input  1  kill the held and incoming instruction.
- out_valid  output  1  op1/op2/sel hold a valid instruction.
- out_ready  input  1  execute stage consumes this cycle.
- op1  output  DATA_W  ALU operand 1.
- op2  output  DATA_W  ALU operand 2.
- sel  output  3  ALU operation code.
- rd_out  output  REG_AW  forwarded destination index.
- reg_write_out  output  1  forwarded write enable; forced to 0 when out_valid=0.
- div_zero  output  1  registered: sel==3'b100 and op2==0.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0, including out_valid, op1, op2, sel, rd_out, reg_write_out and div_zero. in_ready goes to 1 once reset is released. Reset asserted mid-transfer discards the held instruction.
- Handshake: in_ready = !out_valid || out_ready (combinational). A capture occurs on a rising edge when in_valid && in_ready && !flush.
- Capture behaviour:
  - On capture, out_valid goes to 1 and all payload registers load.
  - If out_valid && out_ready and there is no capture, out_valid goes to 0; the payload holds its last value, but reg_write_out is forced to 0.
  - If out_valid && !out_ready, all outputs hold.
- Flush has priority over every other event: on the next edge out_valid=0 and reg_write_out=0, and the incoming instruction is dropped even if in_valid=1.
- Bypass, evaluated combinationally on the input side before capture, per source (rs and rt independently):
  - Use mem_data if mem_wr_en && mem_rd==addr && addr!=0.
  - Else use wb_data if wb_wr_en && wb_rd==addr && addr!=0.
  - Else use rs_data/rt_data.
  - MEM has priority over WB when both match.
  - Register 0 never forwards; its raw register-file value passes through.
- Operand select:
  - op1 = bypassed rs.
  - op2 = use_imm ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : bypassed rt.
  - When use_imm=1 the rt bypass is ignored.
- div_zero is computed from the captured sel and op2 values and registered alongside them, so it is valid exactly when out_valid=1. It is cleared on flush.
- Latency: one cycle from an accepted input to out_valid. Throughput is one instruction per cycle while out_ready=1.
- No combinational path from in_* to op1/op2/sel. The only combinational path from out_ready is to in_ready.

Test Plan:
- Reset then single accept: in_valid=1, rs_data=5, rt_data=7, use_imm=0, alu_sel_in=000 -> next cycle out_valid=1, op1=5, op2=7, sel=000, in_ready=1.
- Immediate sign-extension: use_imm=1, imm=16'hFFFE -> op2=32'hFFFF_FFFE. With imm=16'h7FFF -> op2=32'h0000_7FFF.
- Bypass priority: rs_addr=3, mem_wr_en=1, mem_rd=3, mem_data=0xAA, wb_wr_en=1, wb_rd=3, wb_data=0xBB -> op1=0xAA. Repeat with mem_wr_en=0 -> op1=0xBB. Repeat with rs_addr=0 and rs_data=0 -> op1=0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and op1/op2/sel stable. Then out_ready=1 -> next instruction captured, with no loss or duplication.
- Flush: out_valid=1, flush=1 together with in_valid=1 -> next cycle out_valid=0 and reg_write_out=0, and the incoming instruction does not appear later.
- Divide-by-zero flag: alu_sel_in=100, use_imm=0, rt_data=0 -> div_zero=1 with out_valid=1. Same instruction with rt_data=4 -> div_zero=0. Assert rst_n low mid-stall -> all outputs are 0 immediately.
